triangle_setup: RTL

Per-triangle setup stage directly upstream of the rasterizer. It accepts three screen-space vertices plus a colour and computes everything the rasterizer consumes: edge coefficients, the clamped bounding box, and the 2^24/area reciprocal. It rejects degenerate triangles and, optionally, back-facing ones. It then pulses `rasterizer_start`, holds all outputs stable, and waits for `rasterizer_done` before accepting the next triangle.

---
 rtl/triangle_setup.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/triangle_setup.sv
// rtl/triangle_setup.sv - per-triangle edge, bounding-box and area-reciprocal setup ahead of the rasterizer
module triangle_setup #(
    parameter int CULL_BACKFACE = 0,
    parameter int SCREEN_W      = 320,
    parameter int SCREEN_H      = 240
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [8:0]         x1,
    input  logic [8:0]         x2,
    input  logic [8:0]         x3,
    input  logic [7:0]         y1,
    input  logic [7:0]         y2,
    input  logic [7:0]         y3,
    input  logic [15:0]        z1_in,
    input  logic [15:0]        z2_in,
    input  logic [15:0]        z3_in,
    input  logic [7:0]         color_in,
    output logic signed [9:0]  a1,
    output logic signed [9:0]  b1,
    output logic signed [9:0]  a2,
    output logic signed [9:0]  b2,
    output logic signed [9:0]  a3,
    output logic signed [9:0]  b3,
    output logic signed [17:0] c1,
    output logic signed [17:0] c2,
    output logic signed [17:0] c3,
    output logic [8:0]         bbxi,
    output logic [8:0]         bbxf,
    output logic [7:0]         bbyi,
    output logic [7:0]         bbyf,
    output logic [15:0]        z1,
    output logic [15:0]        z2,
    output logic [15:0]        z3,
    output logic [7:0]         color,
    output logic [31:0]        inv_area,
    output logic               rasterizer_start,
    input  logic               rasterizer_done,
    output logic [15:0]        cull_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DIFF,
        S_PROD,
        S_COEF,
        S_AREA,
        S_CHECK,
        S_DIV,
        S_START,
        S_WAIT
    } state_t;

    localparam logic [8:0] X_MAX = 9'(SCREEN_W - 1);
    localparam logic [7:0] Y_MAX = 8'(SCREEN_H - 1);

    state_t state, state_next;

    logic [8:0]  vx1, vx2, vx3;
    logic [7:0]  vy1, vy2, vy3;
    logic [15:0] vz1, vz2, vz3;
    logic [7:0]  vcolor;

    logic [16:0] p23, p32, p31, p13, p12, p21;

    logic signed [18:0] area;
    logic [19:0]        rem;
    logic [4:0]         div_cnt;

    logic signed [20:0] area_sum;
    logic               cull;
    logic [19:0]        rem_shift;
    logic [19:0]        divisor;
    logic               q_bit;
    logic [8:0]         x_lo, x_hi;
    logic [7:0]         y_lo, y_hi;

    function automatic logic [8:0] min3_x(input logic [8:0] p, input logic [8:0] q, input logic [8:0] r);
        logic [8:0] m;
        m = (p < q) ? p : q;
        return (m < r) ? m : r;
    endfunction

    function automatic logic [8:0] max3_x(input logic [8:0] p, input logic [8:0] q, input logic [8:0] r);
        logic [8:0] m;
        m = (p > q) ? p : q;
        return (m > r) ? m : r;
    endfunction

    function automatic logic [7:0] min3_y(input logic [7:0] p, input logic [7:0] q, input logic [7:0] r);
        logic [7:0] m;
        m = (p < q) ? p : q;
        return (m < r) ? m : r;
    endfunction

    function automatic logic [7:0] max3_y(input logic [7:0] p, input logic [7:0] q, input logic [7:0] r);
        logic [7:0] m;
        m = (p > q) ? p : q;
        return (m > r) ? m : r;
    endfunction

    assign tri_ready        = (state == S_IDLE);
    assign rasterizer_start = (state == S_START);

    // Signed area is evaluated at vertex 1 against edge 1, in a width that cannot overflow
    always_comb begin
        area_sum = ({{11{a1[9]}}, a1} * $signed({12'b0, vx1}))
                 + ({{11{b1[9]}}, b1} * $signed({13'b0, vy1}))
                 + {{3{c1[17]}}, c1};
    end

    always_comb begin
        cull = (area == 19'sd0) || (area[18] && (CULL_BACKFACE != 0));
    end

    // Restoring divider: dividend 2^24 contributes a single 1 bit at quotient position 24
    always_comb begin
        rem_shift = {rem[18:0], (div_cnt == 5'd24)};
        divisor   = {1'b0, area};
        q_bit     = (rem_shift >= divisor);
    end

    always_comb begin
        x_lo = min3_x(vx1, vx2, vx3);
        x_hi = max3_x(vx1, vx2, vx3);
        y_lo = min3_y(vy1, vy2, vy3);
        y_hi = max3_y(vy1, vy2, vy3);
        if (x_lo > X_MAX) x_lo = X_MAX;
        if (x_hi > X_MAX) x_hi = X_MAX;
        if (y_lo > Y_MAX) y_lo = Y_MAX;
        if (y_hi > Y_MAX) y_hi = Y_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (tri_valid) state_next = S_DIFF;
            S_DIFF:  state_next = S_PROD;
            S_PROD:  state_next = S_COEF;
            S_COEF:  state_next = S_AREA;
            S_AREA:  state_next = S_CHECK;
            S_CHECK: state_next = cull ? S_IDLE : S_DIV;
            S_DIV:   if (div_cnt == 5'd0) state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT:  if (rasterizer_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vx1 <= '0; vx2 <= '0; vx3 <= '0;
            vy1 <= '0; vy2 <= '0; vy3 <= '0;
            vz1 <= '0; vz2 <= '0; vz3 <= '0;
            vcolor <= '0;
            p23 <= '0; p32 <= '0; p31 <= '0; p13 <= '0; p12 <= '0; p21 <= '0;
            a1 <= '0; b1 <= '0; a2 <= '0; b2 <= '0; a3 <= '0; b3 <= '0;
            c1 <= '0; c2 <= '0; c3 <= '0;
            bbxi <= '0; bbxf <= '0; bbyi <= '0; bbyf <= '0;
            z1 <= '0; z2 <= '0; z3 <= '0;
            color <= '0;
            area <= '0;
            rem <= '0;
            div_cnt <= '0;
            inv_area <= '0;
            cull_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tri_valid) begin
                        vx1 <= x1; vx2 <= x2; vx3 <= x3;
                        vy1 <= y1; vy2 <= y2; vy3 <= y3;
                        vz1 <= z1_in; vz2 <= z2_in; vz3 <= z3_in;
                        vcolor <= color_in;
                    end
                end
                S_DIFF: begin
                    a1 <= {2'b0, vy2} - {2'b0, vy3};
                    b1 <= {1'b0, vx3} - {1'b0, vx2};
                    a2 <= {2'b0, vy3} - {2'b0, vy1};
                    b2 <= {1'b0, vx1} - {1'b0, vx3};
                    a3 <= {2'b0, vy1} - {2'b0, vy2};
                    b3 <= {1'b0, vx2} - {1'b0, vx1};
                    z1 <= vz1; z2 <= vz2; z3 <= vz3;
                    color <= vcolor;
                end
                S_PROD: begin
                    p23 <= {8'b0, vx2} * {9'b0, vy3};
                    p32 <= {8'b0, vx3} * {9'b0, vy2};
                    p31 <= {8'b0, vx3} * {9'b0, vy1};
                    p13 <= {8'b0, vx1} * {9'b0, vy3};
                    p12 <= {8'b0, vx1} * {9'b0, vy2};
                    p21 <= {8'b0, vx2} * {9'b0, vy1};
                end
                S_COEF: begin
                    c1 <= {1'b0, p23} - {1'b0, p32};
                    c2 <= {1'b0, p31} - {1'b0, p13};
                    c3 <= {1'b0, p12} - {1'b0, p21};
                    bbxi <= x_lo;
                    bbxf <= x_hi;
                    bbyi <= y_lo;
                    bbyf <= y_hi;
                end
                S_AREA: begin
                    area <= area_sum[18:0];
                end
                S_CHECK: begin
                    if (cull) begin
                        if (cull_count != 16'hFFFF) cull_count <= cull_count + 16'd1;
                    end else begin
                        // Clockwise triangles are rendered by flipping every edge function
                        if (area[18]) begin
                            a1 <= -a1; b1 <= -b1; c1 <= -c1;
                            a2 <= -a2; b2 <= -b2; c2 <= -c2;
                            a3 <= -a3; b3 <= -b3; c3 <= -c3;
                            area <= -area;
                        end
                        inv_area <= '0;
                        rem <= '0;
                        div_cnt <= 5'd24;
                    end
                end
                S_DIV: begin
                    rem <= q_bit ? (rem_shift - divisor) : rem_shift;
                    inv_area <= {inv_area[30:0], q_bit};
                    div_cnt <= div_cnt - 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
